fft_bitrev_reorder: RTL
=======================

// Module: fft_bitrev_reorder
// PURPOSE
//   Output reorder stage of the 512-point, 16-lane FFT. Sits directly after the final CBFP
//   renormalisation shifter. Accepts its 13-bit re/im lane vectors in bit-reversed bin order
//   and re-emits each frame in natural bin order. Uses a ping-pong double buffer, so frame
//   k+1 is written while frame k is read out.
// PARAMETERS
//   DATA   13   signed sample width per re/im lane (matches shifter output DATA-4)
//   ARRAY  16   lanes per beat; power of two
//   N      512  points per frame; power of two. Derived: LOG2N=$clog2(N), BEATS=N/ARRAY (32)
// PORTS
//   clk        in   1             single clock, all logic posedge
//   rstn       in   1             reset, synchronous, active-low
//   valid_in   in   1             beat qualifier; frames arrive as BEATS qualified beats
//   re_in      in   DATA x ARRAY  signed real lanes, bit-reversed order
//   im_in      in   DATA x ARRAY  signed imag lanes, bit-reversed order
//   re_out     out  DATA x ARRAY  signed real lanes, natural order, registered
//   im_out     out  DATA x ARRAY  signed imag lanes, natural order, registered
//   valid_out  out  1             output beat qualifier, registered
// BEHAVIOUR
//   - Reset: synchronous on rstn=0. Clears valid_out, re_out, im_out, wr_beat, rd_beat,
//     wr_bank, rd_active, and any partial frame. Buffer contents are not reset (don't-care).
//     Reset mid-frame discards the partial input frame and the in-flight output frame.
//   - Write side: wr_beat (log2 BEATS bits) increments on each valid_in and wraps BEATS-1->0.
//     Lane l at beat b is position p=b*ARRAY+l. It is stored in bank[wr_bank] at address
//     bitrev_LOG2N(p), for both re and im. valid_in=0 cycles stall wr_beat; gaps are allowed.
//   - Frame complete: on the edge that accepts beat BEATS-1:
//     wr_bank toggles, rd_bank<=old wr_bank, rd_active<=1, rd_beat<=0.
//   - Read side: while rd_active, each cycle sets re_out[l]/im_out[l] <= bank[rd_bank][rd_beat*ARRAY+l],
//     sets valid_out<=1 and increments rd_beat. After beat BEATS-1, rd_active<=0.
//     No backpressure; output beats are contiguous (BEATS cycles per frame).
//   - Latency: first natural beat is valid on the edge after the last input beat was accepted (1 clk).
//   - When not rd_active: valid_out<=0; re_out/im_out hold their last value.
//   - Simultaneous events: a frame may complete on the same edge that issues the last read
//     of the previous frame (back-to-back 1 beat/clk input). The new read starts on the next
//     edge with no bubble. Bank conflict is impossible at <=1 beat/clk.
//   - Buffer read is combinational from the register array, registered at the output.
//     Writes and reads always target opposite banks.
// CONFIGURATION
//   REORDER_FRAME_MARK_EN
//     defined:     adds outputs sop_out (1) and eop_out (1), registered alongside valid_out.
//                  sop_out=1 on output beat 0, eop_out=1 on beat BEATS-1; both 0 otherwise
//                  and after reset.
//     not defined: ports absent; all other behaviour identical.
// TESTING
//   1 Reset: rstn=0 for 3 clk with random valid_in -> valid_out=0, re_out=im_out=0 throughout.
//   2 One frame, 32 contiguous beats, re_in[l]=p, im_in[l]=-p.
//     -> valid_out high for exactly 32 clk, starting 1 clk after input beat 31.
//     -> out beat 0: lane0 re=0, lane1 re=256, lane2 re=128.
//     -> out beat 31: lane15 re=511, im=-511.
//   3 Back-to-back frames A (re=p) and B (re=p+1000), no gap.
//     -> 64 contiguous valid_out beats, A then B, B beat0 lane1 re=1256.
//   4 Gapped input: valid_in toggles 1/0 over 64 clk -> same natural-order data as test 2;
//     valid_out starts 1 clk after the 32nd accepted beat.
//   5 Reset mid-frame: 10 beats, rstn=0 for 1 clk, then a full frame (re=p+2000).
//     -> exactly 32 output beats, beat0 lane0 re=2000; no stale data.
//   6 REORDER_FRAME_MARK_EN defined, test 3 stimulus -> sop_out on beats 0 and 32,
//     eop_out on beats 31 and 63.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
//   Output reorder stage of the 512-point, 16-lane FFT. Frames arrive as BEATS
//   beats of ARRAY re/im lanes in bit-reversed bin order and leave in natural
//   bin order. A ping-pong double buffer lets frame k+1 be written while frame
//   k is read out, so back-to-back frames stream with no bubble.
//
//   Ports
//     clk        : clock, all logic on posedge
//     rstn       : synchronous active-low reset
//     valid_in   : input beat qualifier (gaps allowed)
//     re_in/im_in: ARRAY x DATA signed lanes, bit-reversed order
//     re_out/im_out : ARRAY x DATA signed lanes, natural order, registered
//     valid_out  : output beat qualifier, registered
//     sop_out/eop_out : first/last output beat of a frame (only when the
//                  REORDER_FRAME_MARK_EN macro is defined)
//
//   Storage organisation
//     Position p = {b, l} lands at address bitrev(p) = {rev(l), rev(b)}. The
//     buffer is therefore split into ARRAY slices, slice s holding addresses
//     s*BEATS .. s*BEATS+BEATS-1, and slice s is only ever written by input
//     lane rev(s) at index rev(b): one write port per slice. A natural-order
//     read beat covers ARRAY consecutive addresses, which all live in one slice
//     (requires ARRAY <= BEATS, i.e. N >= ARRAY*ARRAY).
// ---------------------------------------------------------------------------

// One address slice of the double buffer: single write port, ARRAY-wide
// combinational read of an ARRAY-aligned block.
module fft_bitrev_slice #(
  parameter int DATA  = 13,
  parameter int ARRAY = 16,
  parameter int BEATS = 32,
  localparam int LOG2B = $clog2(BEATS)
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic                        wr_bank_i,
  input  logic [LOG2B-1:0]            wr_idx_i,
  input  logic [DATA-1:0]             wr_re_i,
  input  logic [DATA-1:0]             wr_im_i,
  input  logic                        rd_bank_i,
  input  logic [LOG2B-1:0]            rd_base_i,
  output logic [ARRAY-1:0][DATA-1:0]  rd_re_o,
  output logic [ARRAY-1:0][DATA-1:0]  rd_im_o
);
  // Contents are never reset; they are only read after being written.
  logic [2*DATA-1:0] mem_q [2][BEATS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_bank_i][wr_idx_i] <= {wr_re_i, wr_im_i};
  end

  // rd_base_i is ARRAY-aligned, so OR-ing in the lane index forms the address.
  for (genvar l = 0; l < ARRAY; l++) begin : g_rd
    assign {rd_re_o[l], rd_im_o[l]} = mem_q[rd_bank_i][rd_base_i | LOG2B'(l)];
  end
endmodule

module fft_bitrev_reorder #(
  parameter int DATA  = 13,
  parameter int ARRAY = 16,
  parameter int N     = 512
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        valid_in,
  input  logic [ARRAY-1:0][DATA-1:0]  re_in,
  input  logic [ARRAY-1:0][DATA-1:0]  im_in,
  output logic [ARRAY-1:0][DATA-1:0]  re_out,
  output logic [ARRAY-1:0][DATA-1:0]  im_out,
`ifdef REORDER_FRAME_MARK_EN
  output logic                        sop_out,
  output logic                        eop_out,
`endif
  output logic                        valid_out
);
  localparam int LOG2N = $clog2(N);
  localparam int LOG2A = $clog2(ARRAY);
  localparam int BEATS = N / ARRAY;
  localparam int LOG2B = $clog2(BEATS);

  function automatic int rev_bits(input int v, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) r = r | (((v >> i) & 1) << (w - 1 - i));
    return r;
  endfunction

  typedef logic [ARRAY-1:0][DATA-1:0] vec_t;

  logic [LOG2B-1:0] wr_beat_q, wr_beat_d;
  logic [LOG2B-1:0] rd_beat_q, rd_beat_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             rd_active_q, rd_active_d;
  logic             valid_q, valid_d;
  vec_t             re_q, re_d, im_q, im_d;
`ifdef REORDER_FRAME_MARK_EN
  logic             sop_q, sop_d, eop_q, eop_d;
`endif

  // Write index is the bit-reversed beat number.
  logic [LOG2B-1:0] wr_idx;
  for (genvar i = 0; i < LOG2B; i++) begin : g_wr_idx
    assign wr_idx[i] = wr_beat_q[LOG2B-1-i];
  end

  // Natural read address of lane 0: upper bits pick the slice, lower bits the
  // aligned block inside it.
  logic [LOG2N-1:0] rd_addr;
  logic [LOG2B-1:0] rd_base;
  logic [LOG2A-1:0] rd_slice;
  assign rd_addr  = {rd_beat_q, LOG2A'(0)};
  assign rd_base  = rd_addr[LOG2B-1:0];
  assign rd_slice = rd_addr[LOG2N-1:LOG2B];

  logic we;
  assign we = valid_in & rstn;

  vec_t sl_re [ARRAY];
  vec_t sl_im [ARRAY];

  for (genvar s = 0; s < ARRAY; s++) begin : g_slice
    localparam int SRC = rev_bits(s, LOG2A);
    fft_bitrev_slice #(.DATA(DATA), .ARRAY(ARRAY), .BEATS(BEATS)) u_slice (
      .clk       (clk),
      .we_i      (we),
      .wr_bank_i (wr_bank_q),
      .wr_idx_i  (wr_idx),
      .wr_re_i   (re_in[SRC]),
      .wr_im_i   (im_in[SRC]),
      .rd_bank_i (rd_bank_q),
      .rd_base_i (rd_base),
      .rd_re_o   (sl_re[s]),
      .rd_im_o   (sl_im[s])
    );
  end

  always_comb begin
    wr_beat_d   = wr_beat_q;
    wr_bank_d   = wr_bank_q;
    rd_beat_d   = rd_beat_q;
    rd_bank_d   = rd_bank_q;
    rd_active_d = rd_active_q;
    valid_d     = 1'b0;
    re_d        = re_q;
    im_d        = im_q;
`ifdef REORDER_FRAME_MARK_EN
    sop_d       = rd_active_q && (rd_beat_q == '0);
    eop_d       = rd_active_q && (rd_beat_q == LOG2B'(BEATS-1));
`endif
    if (rd_active_q) begin
      re_d      = sl_re[rd_slice];
      im_d      = sl_im[rd_slice];
      valid_d   = 1'b1;
      rd_beat_d = rd_beat_q + 1'b1;
      if (rd_beat_q == LOG2B'(BEATS-1)) rd_active_d = 1'b0;
    end
    // Frame completion wins over the end of the previous read so a
    // back-to-back frame starts reading on the very next edge.
    if (valid_in) begin
      wr_beat_d = wr_beat_q + 1'b1;
      if (wr_beat_q == LOG2B'(BEATS-1)) begin
        wr_bank_d   = ~wr_bank_q;
        rd_bank_d   = wr_bank_q;
        rd_active_d = 1'b1;
        rd_beat_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_beat_q   <= '0;
      wr_bank_q   <= 1'b0;
      rd_beat_q   <= '0;
      rd_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      valid_q     <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
`ifdef REORDER_FRAME_MARK_EN
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
`endif
    end else begin
      wr_beat_q   <= wr_beat_d;
      wr_bank_q   <= wr_bank_d;
      rd_beat_q   <= rd_beat_d;
      rd_bank_q   <= rd_bank_d;
      rd_active_q <= rd_active_d;
      valid_q     <= valid_d;
      re_q        <= re_d;
      im_q        <= im_d;
`ifdef REORDER_FRAME_MARK_EN
      sop_q       <= sop_d;
      eop_q       <= eop_d;
`endif
    end
  end

  assign re_out    = re_q;
  assign im_out    = im_q;
  assign valid_out = valid_q;
`ifdef REORDER_FRAME_MARK_EN
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;
`endif
endmodule
